// File: rtl/tt_lpf_pkg.sv
// tt_lpf_pkg: shared types, error encoding and the signed clamp used by the PI loop filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tt_lpf_pkg;

   typedef enum logic {
      ACQ   = 1'b0,
      TRACK = 1'b1
   } lpf_mode_e;

   // Phase error as a 2-bit signed value
   localparam logic [1:0] ERR_ZERO = 2'b00;
   localparam logic [1:0] ERR_POS  = 2'b01;
   localparam logic [1:0] ERR_NEG  = 2'b11;

   // Widest intermediate the clamp accepts; callers sign-extend into it.
   localparam int SAT_MAX_W = 128;

   // Clamp a signed value to the range of an out_w-bit signed word.
   // The result is still SAT_MAX_W wide; callers truncate to out_w.
   function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
      input logic signed [SAT_MAX_W-1:0] val,
      input int unsigned                 out_w
   );
      logic signed [SAT_MAX_W-1:0] max_v;
      logic signed [SAT_MAX_W-1:0] min_v;
      max_v = $signed((SAT_MAX_W'(1) << (out_w - 1)) - SAT_MAX_W'(1));
      min_v = ~max_v;
      if (val > max_v)
         sat_signed = max_v;
      else if (val < min_v)
         sat_signed = min_v;
      else
         sat_signed = val;
   endfunction

endpackage

// File: rtl/tt_lpf_pi_lock_det.sv
// tt_lpf_pi_lock_det: ACQ/TRACK lock FSM with its run-length counter and scan segment.
// Latency: mode changes on the edge that completes the quiet/noisy run.
// Backpressure: none; hold freezes state, scan shifts cnt[0..MSB] then the mode bit.
// Ports: i_clk_gen/i_rst_n clock and async reset, err_nz non-zero phase error,
//        hold freeze, scan_en/scan_in shift controls, mode (1 = TRACK), scan_out chain tail.
module tt_lpf_pi_lock_det
   import tt_lpf_pkg::*;
#(
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 8
) (
   input  logic i_clk_gen,
   input  logic i_rst_n,
   input  logic err_nz,
   input  logic hold,
   input  logic scan_en,
   input  logic scan_in,
   output logic mode,
   output logic scan_out
);

   localparam int CNT_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CNT - 1);
   localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_CNT - 1);

   lpf_mode_e        mode_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W:0]   cnt_shift;

   // Top bit of this concatenation is the old cnt MSB, which moves into the mode bit.
   assign cnt_shift = {cnt, scan_in};

   always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mode_q <= ACQ;
         cnt    <= '0;
      end else if (scan_en) begin
         cnt    <= cnt_shift[CNT_W-1:0];
         mode_q <= lpf_mode_e'(cnt_shift[CNT_W]);
      end else if (!hold) begin
         if (mode_q == ACQ) begin
            if (err_nz) begin
               cnt <= '0;
            end else if (cnt == LOCK_LAST) begin
               mode_q <= TRACK;
               cnt    <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            if (!err_nz) begin
               cnt <= '0;
            end else if (cnt == UNLOCK_LAST) begin
               mode_q <= ACQ;
               cnt    <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   assign mode     = (mode_q == TRACK);
   assign scan_out = (mode_q == TRACK);

endmodule

// File: rtl/tt_lpf_pi.sv
// tt_lpf_pi: PI loop filter between the PFD and the DCO, saturating, with lock-based gain switching.
// Latency: one register stage; integral term of an error shows in the output one edge later.
// Backpressure: none; i_hold freezes integrator and lock state, i_scan_en freezes output and o_sat.
// Ports: i_clk_gen/i_rst_n clock and async reset (release expected synchronous to i_clk_gen),
//        i_up/i_down PFD pulses, i_kp_*/i_ki_* unsigned gains per mode, i_hold integrator freeze,
//        o_filtered_control_signal signed DCO word, o_locked TRACK flag, o_sat clamp flag,
//        i_scan_en/i_scan_in/o_scan_out scan chain acc[0..] -> cnt -> mode.
module tt_lpf_pi
   import tt_lpf_pkg::*;
#(
   parameter int ACC_W      = 32,
   parameter int K_W        = 8,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 8
) (
   input  logic             i_clk_gen,
   input  logic             i_rst_n,
   input  logic             i_up,
   input  logic             i_down,
   input  logic [K_W-1:0]   i_kp_acq,
   input  logic [K_W-1:0]   i_ki_acq,
   input  logic [K_W-1:0]   i_kp_trk,
   input  logic [K_W-1:0]   i_ki_trk,
   input  logic             i_hold,
   output logic [ACC_W-1:0] o_filtered_control_signal,
   output logic             o_locked,
   output logic             o_sat,
   input  logic             i_scan_en,
   input  logic             i_scan_in,
   output logic             o_scan_out
);

   localparam int SUM_W = ACC_W + K_W + 1;

   logic [1:0]                  err;
   logic                        err_nz;
   logic                        mode_trk;
   logic [K_W-1:0]              kp_sel;
   logic [K_W-1:0]              ki_sel;
   logic signed [K_W:0]         p_term;
   logic signed [K_W:0]         i_term;
   logic signed [SUM_W-1:0]     int_sum;
   logic signed [SUM_W-1:0]     prop_sum;
   logic signed [SAT_MAX_W-1:0] int_sat_w;
   logic signed [SAT_MAX_W-1:0] prop_sat_w;
   logic                        acc_clamp;
   logic                        out_clamp;
   logic signed [ACC_W-1:0]     acc;
   logic signed [ACC_W-1:0]     out_q;

   // Error is only +/-1 or 0, so the "multiply" is a conditional negate of the gain.
   function automatic logic signed [K_W:0] gain_term(input logic [K_W-1:0] k, input logic [1:0] e);
      if (e == ERR_POS)
         gain_term = $signed({1'b0, k});
      else if (e == ERR_NEG)
         gain_term = -$signed({1'b0, k});
      else
         gain_term = '0;
   endfunction

   always_comb begin
      err = ERR_ZERO;
      if (i_down && !i_up)
         err = ERR_POS;
      else if (i_up && !i_down)
         err = ERR_NEG;
   end

   assign err_nz = i_up ^ i_down;
   assign kp_sel = mode_trk ? i_kp_trk : i_kp_acq;
   assign ki_sel = mode_trk ? i_ki_trk : i_ki_acq;
   assign p_term = gain_term(kp_sel, err);
   assign i_term = gain_term(ki_sel, err);

   // Both paths start from the pre-update accumulator.
   assign int_sum    = SUM_W'(acc) + SUM_W'(i_term);
   assign prop_sum   = SUM_W'(acc) + SUM_W'(p_term);
   assign int_sat_w  = sat_signed(SAT_MAX_W'(int_sum), ACC_W);
   assign prop_sat_w = sat_signed(SAT_MAX_W'(prop_sum), ACC_W);
   assign acc_clamp  = (int_sat_w != SAT_MAX_W'(int_sum));
   assign out_clamp  = (prop_sat_w != SAT_MAX_W'(prop_sum));

   always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc   <= '0;
         out_q <= '0;
         o_sat <= 1'b0;
      end else if (i_scan_en) begin
         acc <= {acc[ACC_W-2:0], i_scan_in};
      end else begin
         out_q <= ACC_W'(prop_sat_w);
         // A held integrator cannot clamp, so only the output path flags then.
         o_sat <= out_clamp | (acc_clamp & ~i_hold);
         if (!i_hold)
            acc <= ACC_W'(int_sat_w);
      end
   end

   tt_lpf_pi_lock_det #(
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_CNT (UNLOCK_CNT)
   ) u_lock_det (
      .i_clk_gen (i_clk_gen),
      .i_rst_n   (i_rst_n),
      .err_nz    (err_nz),
      .hold      (i_hold),
      .scan_en   (i_scan_en),
      .scan_in   (acc[ACC_W-1]),
      .mode      (mode_trk),
      .scan_out  (o_scan_out)
   );

   assign o_filtered_control_signal = out_q;
   assign o_locked                  = mode_trk;

endmodule

// File: tb/tb_tt_lpf_pi.sv
// tb_tt_lpf_pi: directed bench for the PI loop filter (ACC_W=32, LOCK_CNT=4, UNLOCK_CNT=3).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_tt_lpf_pi;

   localparam int ACC_W   = 32;
   localparam int K_W     = 8;
   localparam int CHAIN_W = 36;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             up, down, hold, scan_en, scan_in;
   logic [K_W-1:0]   kp_acq, ki_acq, kp_trk, ki_trk;
   logic [ACC_W-1:0] out_w;
   logic             locked, sat, scan_out;

   int checks   = 0;
   int failures = 0;

   logic [63:0]        rnd;
   logic [CHAIN_W-1:0] pat;

   always #5 clk = ~clk;

   tt_lpf_pi #(
      .ACC_W      (ACC_W),
      .K_W        (K_W),
      .LOCK_CNT   (4),
      .UNLOCK_CNT (3)
   ) dut (
      .i_clk_gen                 (clk),
      .i_rst_n                   (rst_n),
      .i_up                      (up),
      .i_down                    (down),
      .i_kp_acq                  (kp_acq),
      .i_ki_acq                  (ki_acq),
      .i_kp_trk                  (kp_trk),
      .i_ki_trk                  (ki_trk),
      .i_hold                    (hold),
      .o_filtered_control_signal (out_w),
      .o_locked                  (locked),
      .o_sat                     (sat),
      .i_scan_en                 (scan_en),
      .i_scan_in                 (scan_in),
      .o_scan_out                (scan_out)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_st(input string tag, input logic [31:0] o, input logic l, input logic s);
      check({tag, ".out"}, 64'(out_w), 64'(o));
      check({tag, ".locked"}, 64'(locked), 64'(l));
      check({tag, ".sat"}, 64'(sat), 64'(s));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic scan_shift(input logic b);
      scan_en = 1'b1;
      scan_in = b;
      @(posedge clk);
      #1;
   endtask

   // Chain vector is {mode, cnt[2:0], acc[31:0]}; the mode bit goes in first.
   task automatic scan_load(input logic [CHAIN_W-1:0] c);
      for (int i = CHAIN_W - 1; i >= 0; i--)
         scan_shift(c[i]);
      scan_en = 1'b0;
      scan_in = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b1;
      up      = 1'b0;
      down    = 1'b0;
      hold    = 1'b0;
      scan_en = 1'b0;
      scan_in = 1'b0;
      kp_acq  = 8'd7;
      ki_acq  = 8'd4;
      kp_trk  = 8'd2;
      ki_trk  = 8'd1;

      // Reset state, before any clock edge
      #1 rst_n = 1'b0;
      #2;
      check_st("rst", 32'd0, 1'b0, 1'b0);
      check("rst.scan_out", 64'(scan_out), 64'd0);
      #9 rst_n = 1'b1;

      // Down held 3 cycles: out = acc + 7 with acc stepping by 4
      down = 1'b1;
      step(); check_st("dn1", 32'd7, 1'b0, 1'b0);
      step(); check_st("dn2", 32'd11, 1'b0, 1'b0);
      step(); check_st("dn3", 32'd15, 1'b0, 1'b0);

      // Idle: out = acc = 12, lock on the 4th quiet edge
      down = 1'b0;
      step(); check_st("idle1", 32'd12, 1'b0, 1'b0);
      step(); check_st("idle2", 32'd12, 1'b0, 1'b0);
      step(); check_st("idle3", 32'd12, 1'b0, 1'b0);
      step(); check_st("idle4", 32'd12, 1'b1, 1'b0);

      // Up in TRACK: kp=2, ki=1; unlock on the 3rd noisy edge
      up = 1'b1;
      step(); check_st("up1", 32'd10, 1'b1, 1'b0);
      step(); check_st("up2", 32'd9, 1'b1, 1'b0);
      step(); check_st("up3", 32'd8, 1'b0, 1'b0);
      up = 1'b0;
      step(); check_st("up_idle", 32'd9, 1'b0, 1'b0);

      // Positive clamp
      scan_load({1'b0, 3'd0, 32'h7FFF_FFFE});
      check_st("posload", 32'd9, 1'b0, 1'b0);
      down = 1'b1;
      step(); check_st("pos1", 32'h7FFF_FFFF, 1'b0, 1'b1);
      step(); check_st("pos2", 32'h7FFF_FFFF, 1'b0, 1'b1);
      down = 1'b0;
      step(); check_st("pos_idle", 32'h7FFF_FFFF, 1'b0, 1'b0);

      // Negative clamp
      scan_load({1'b0, 3'd0, 32'h8000_0001});
      check_st("negload", 32'h7FFF_FFFF, 1'b0, 1'b0);
      up = 1'b1;
      step(); check_st("neg1", 32'h8000_0000, 1'b0, 1'b1);
      step(); check_st("neg2", 32'h8000_0000, 1'b0, 1'b1);
      up = 1'b0;
      step(); check_st("neg_idle", 32'h8000_0000, 1'b0, 1'b0);

      // Hold: acc=100, build cnt to 3, then hold through noise and quiet
      scan_load({1'b0, 3'd0, 32'd100});
      step(); check_st("h_pre1", 32'd100, 1'b0, 1'b0);
      step(); check_st("h_pre2", 32'd100, 1'b0, 1'b0);
      step(); check_st("h_pre3", 32'd100, 1'b0, 1'b0);
      hold = 1'b1;
      down = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(); check_st("h_dn", 32'd107, 1'b0, 1'b0);
      end
      down = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(); check_st("h_idle", 32'd100, 1'b0, 1'b0);
      end
      // Frozen cnt=3 survives the noise, so the first free quiet edge locks
      hold = 1'b0;
      step(); check_st("h_rel", 32'd100, 1'b1, 1'b0);

      // Hold with output clamp only; acc must stay at 0x7FFF_FFFE
      scan_load({1'b0, 3'd0, 32'h7FFF_FFFE});
      hold = 1'b1;
      down = 1'b1;
      step(); check_st("h_sat", 32'h7FFF_FFFF, 1'b0, 1'b1);
      hold = 1'b0;
      down = 1'b0;
      step(); check_st("h_sat_idle", 32'h7FFF_FFFE, 1'b0, 1'b0);

      // Scan round trip: pattern in, then shifted back out on o_scan_out
      rnd = {$urandom(), $urandom()};
      pat = rnd[CHAIN_W-1:0];
      for (int k = 0; k < CHAIN_W; k++)
         scan_shift(pat[k]);
      check_st("rt_in", 32'h7FFF_FFFE, scan_out, 1'b0);
      for (int m = 0; m < CHAIN_W; m++) begin
         check("rt_bit", 64'(scan_out), 64'(pat[m]));
         scan_shift(1'b0);
         check("rt_out", 64'(out_w), 64'h7FFF_FFFE);
      end

      // Fill the chain with ones (mode=TRACK), then reset mid-scan off-edge
      for (int k = 0; k < CHAIN_W; k++)
         scan_shift(1'b1);
      check("ones.scan_out", 64'(scan_out), 64'd1);
      check("ones.locked", 64'(locked), 64'd1);
      #3 rst_n = 1'b0;
      #1;
      check_st("rst_scan", 32'd0, 1'b0, 1'b0);
      check("rst_scan.scan_out", 64'(scan_out), 64'd0);
      scan_en = 1'b0;
      scan_in = 1'b0;
      #2 rst_n = 1'b1;

      // Reach TRACK with acc=8, then reset off-edge
      down = 1'b1;
      step(); check_st("t_dn1", 32'd7, 1'b0, 1'b0);
      step(); check_st("t_dn2", 32'd11, 1'b0, 1'b0);
      down = 1'b0;
      step(); step(); step();
      check_st("t_idle3", 32'd8, 1'b0, 1'b0);
      step(); check_st("t_lock", 32'd8, 1'b1, 1'b0);
      check("t_lock.scan_out", 64'(scan_out), 64'd1);
      #3 rst_n = 1'b0;
      #1;
      check_st("rst_trk", 32'd0, 1'b0, 1'b0);
      check("rst_trk.scan_out", 64'(scan_out), 64'd0);
      #2 rst_n = 1'b1;
      step(); check_st("post_rst", 32'd0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
